// File: rtl/hps_soc_ctrl.sv
// HPS soft-SoC control block: per-core reset sequencing with release stretch,
// plus synchronised interrupt collection (level or rising-edge latched) that
// is masked and forwarded onto the 32-bit fabric-to-HPS interrupt vector.
module hps_soc_ctrl #(
  parameter int                   NUM_CORES   = 1,
  parameter int                   NUM_IRQ     = 2,
  parameter int                   SYNC_STAGES = 2,
  parameter int                   RST_HOLD    = 16,
  parameter logic [NUM_IRQ-1:0]   IRQ_EDGE    = '0
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic                 ext_rst_i,
  input  logic [NUM_CORES-1:0] pio_rst_i,
  output logic [NUM_CORES-1:0] core_rst_o,
  output logic [NUM_CORES-1:0] core_run_o,
  input  logic [NUM_IRQ-1:0]   irq_src_i,
  input  logic [NUM_IRQ-1:0]   irq_mask_i,
  input  logic [NUM_IRQ-1:0]   irq_clr_i,
  output logic [NUM_IRQ-1:0]   irq_pending_o,
  output logic [31:0]          f2h_irq_o
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Last HOLD count before release; the channel spends exactly RST_HOLD cycles in HOLD.
  localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

  logic [NUM_CORES-1:0] reqSync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0]   irqSync_q [SYNC_STAGES];
  logic [NUM_CORES-1:0] reqS;
  logic [NUM_IRQ-1:0]   irqS;

  // Synchroniser chains for the asynchronous reset requests and interrupt sources.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        reqSync_q[i] <= '0;
        irqSync_q[i] <= '0;
      end
    end else begin
      reqSync_q[0] <= pio_rst_i;
      irqSync_q[0] <= irq_src_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        reqSync_q[i] <= reqSync_q[i-1];
        irqSync_q[i] <= irqSync_q[i-1];
      end
    end
  end

  assign reqS = reqSync_q[SYNC_STAGES-1];
  assign irqS = irqSync_q[SYNC_STAGES-1];

  for (genvar c = 0; c < NUM_CORES; c++) begin : gCore
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rst_q;

    // Next-state logic: any reset request wins over the HOLD->RUN release.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_RESET: begin
          cnt_d = '0;
          if (!reqS[c] && !ext_rst_i) begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (reqS[c] || ext_rst_i) begin
            state_d = ST_RESET;
            cnt_d   = '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_RUN: begin
          if (reqS[c] || ext_rst_i) begin
            state_d = ST_RESET;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase
    end

    // State, counter and the registered core reset, which always mirrors (state != RUN).
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
        state_q <= ST_RESET;
        cnt_q   <= '0;
        rst_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rst_q   <= (state_d != ST_RUN);
      end
    end

    assign core_rst_o[c] = rst_q;
    assign core_run_o[c] = ~rst_q;
  end

  logic [NUM_IRQ-1:0] irqPrev_q;
  logic [NUM_IRQ-1:0] edgePend_q, edgePend_d;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] f2h_q;
  logic [31:0]        f2hVec;

  // Edge latches: a new rising edge beats a clear in the same cycle; level bits never latch.
  always_comb begin
    edgePend_d = ((edgePend_q & ~irq_clr_i) | (irqS & ~irqPrev_q)) & IRQ_EDGE;
  end

  assign pending       = (irqS & ~IRQ_EDGE) | edgePend_q;
  assign irq_pending_o = pending;

  // Edge history, edge latches and the masked forward register.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      irqPrev_q  <= '0;
      edgePend_q <= '0;
      f2h_q      <= '0;
    end else begin
      irqPrev_q  <= irqS;
      edgePend_q <= edgePend_d;
      f2h_q      <= pending & irq_mask_i;
    end
  end

  // Widen the forwarded interrupts onto the full 32-bit vector, upper bits tied low.
  always_comb begin
    f2hVec              = '0;
    f2hVec[NUM_IRQ-1:0] = f2h_q;
  end

  assign f2h_irq_o = f2hVec;

endmodule

// File: tb/tb_hps_soc_ctrl.sv
// Testbench for hps_soc_ctrl: two cores, two interrupts (bit 1 edge, bit 0 level).
module tb_hps_soc_ctrl;

  localparam int          NC   = 2;
  localparam int          NI   = 2;
  localparam int          HOLD = 16;
  localparam logic [1:0]  EDGE = 2'b10;

  logic          wb_clk;
  logic          wb_rst_n;
  logic          ext_rst_i;
  logic [NC-1:0] pio_rst_i;
  logic [NC-1:0] core_rst_o;
  logic [NC-1:0] core_run_o;
  logic [NI-1:0] irq_src_i;
  logic [NI-1:0] irq_mask_i;
  logic [NI-1:0] irq_clr_i;
  logic [NI-1:0] irq_pending_o;
  logic [31:0]   f2h_irq_o;

  hps_soc_ctrl #(
    .NUM_CORES   (NC),
    .NUM_IRQ     (NI),
    .SYNC_STAGES (2),
    .RST_HOLD    (HOLD),
    .IRQ_EDGE    (EDGE)
  ) dut (
    .wb_clk        (wb_clk),
    .wb_rst_n      (wb_rst_n),
    .ext_rst_i     (ext_rst_i),
    .pio_rst_i     (pio_rst_i),
    .core_rst_o    (core_rst_o),
    .core_run_o    (core_run_o),
    .irq_src_i     (irq_src_i),
    .irq_mask_i    (irq_mask_i),
    .irq_clr_i     (irq_clr_i),
    .irq_pending_o (irq_pending_o),
    .f2h_irq_o     (f2h_irq_o)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NC-1:0] rst;
    logic [NC-1:0] run;
    logic [NI-1:0] pend;
    logic [31:0]   f2h;
  } exp_t;

  typedef struct {
    logic [1:0] src;
    logic [1:0] mask;
    logic [1:0] clr;
    logic [1:0] expPend;
    logic [1:0] expF2h;
  } vec_t;

  exp_t sbQ[$];
  vec_t vecs[15];

  // Reference model state: runLen counts consecutive edges seeing no reset request.
  int            runLen [NC];
  logic [NC-1:0] mReq0, mReqS;
  logic [NI-1:0] mIrq0, mIrqS, mPrev, mEdgePend, mF2h;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NI-1:0] modelPend();
    logic [NI-1:0] p;
    for (int i = 0; i < NI; i++) p[i] = EDGE[i] ? mEdgePend[i] : mIrqS[i];
    return p;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < NC; c++) runLen[c] = 0;
    mReq0 = '0; mReqS = '0;
    mIrq0 = '0; mIrqS = '0; mPrev = '0; mEdgePend = '0; mF2h = '0;
  endtask

  task automatic modelStep();
    for (int c = 0; c < NC; c++) begin
      if (mReqS[c] || ext_rst_i) runLen[c] = 0;
      else if (runLen[c] <= HOLD) runLen[c]++;
    end
    mF2h = modelPend() & irq_mask_i;
    for (int i = 0; i < NI; i++) begin
      if (EDGE[i]) begin
        if (mIrqS[i] && !mPrev[i]) mEdgePend[i] = 1'b1;
        else if (irq_clr_i[i])     mEdgePend[i] = 1'b0;
      end
    end
    mPrev = mIrqS; mIrqS = mIrq0; mIrq0 = irq_src_i;
    mReqS = mReq0; mReq0 = pio_rst_i;
  endtask

  function automatic exp_t modelOut();
    exp_t e;
    for (int c = 0; c < NC; c++) e.rst[c] = (runLen[c] <= HOLD);
    e.run  = ~e.rst;
    e.pend = modelPend();
    e.f2h  = {30'b0, mF2h};
    return e;
  endfunction

  // One clock: model and DUT advance on the edge, outputs compared on the falling edge.
  task automatic tick();
    exp_t e;
    @(posedge wb_clk);
    modelStep();
    sbQ.push_back(modelOut());
    @(negedge wb_clk);
    e = sbQ.pop_front();
    checkOutput("sbCoreRst", 32'(core_rst_o), 32'(e.rst));
    checkOutput("sbCoreRun", 32'(core_run_o), 32'(e.run));
    checkOutput("sbPending", 32'(irq_pending_o), 32'(e.pend));
    checkOutput("sbF2h", f2h_irq_o, e.f2h);
  endtask

  task automatic applyStimulus(input logic ext, input logic [NC-1:0] pio,
                               input logic [NI-1:0] src, input logic [NI-1:0] mask,
                               input logic [NI-1:0] clr);
    ext_rst_i  = ext;
    pio_rst_i  = pio;
    irq_src_i  = src;
    irq_mask_i = mask;
    irq_clr_i  = clr;
  endtask

  task automatic doReset();
    @(negedge wb_clk);
    #1;
    wb_rst_n = 1'b0;
    modelReset();
    #2;
    checkOutput("rstCoreRst", 32'(core_rst_o), 32'h3);
    checkOutput("rstCoreRun", 32'(core_run_o), 32'h0);
    checkOutput("rstPending", 32'(irq_pending_o), 32'h0);
    checkOutput("rstF2h", f2h_irq_o, 32'h0);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b00};
    vecs[2]  = '{2'b01, 2'b11, 2'b00, 2'b11, 2'b01};
    vecs[3]  = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b11};
    vecs[4]  = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b11};
    vecs[5]  = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b01};
    vecs[6]  = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
    vecs[7]  = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
    vecs[8]  = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    vecs[9]  = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    vecs[10] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
    vecs[11] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    vecs[12] = '{2'b00, 2'b11, 2'b00, 2'b10, 2'b10};
    vecs[13] = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b10};
    vecs[14] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00};

    wb_rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, '0);
    modelReset();
    doReset();

    // Release stretch after power-on reset.
    for (int i = 1; i <= HOLD + 3; i++) begin
      tick();
      if (i == HOLD)     checkOutput("holdStretch", 32'(core_rst_o), 32'h3);
      if (i == HOLD + 1) checkOutput("releaseRun", 32'(core_run_o), 32'h3);
    end

    // Five-cycle reset request on core 0 only.
    for (int j = 0; j < 26; j++) begin
      applyStimulus(1'b0, (j < 5) ? 2'b01 : 2'b00, '0, '0, '0);
      tick();
      if (j == 1)  checkOutput("pioRiseEarly", 32'(core_rst_o), 32'h0);
      if (j == 2)  checkOutput("pioRiseLat", 32'(core_rst_o), 32'h1);
      if (j == 10) checkOutput("core1Indep", 32'(core_run_o), 32'h2);
      if (j == 22) checkOutput("pioFallHold", 32'(core_rst_o), 32'h1);
      if (j == 23) checkOutput("pioFallRun", 32'(core_rst_o), 32'h0);
    end

    // Board reset pulse at HOLD count 10 restarts the full stretch (also resets mid-RUN).
    doReset();
    for (int i = 1; i <= 31; i++) begin
      applyStimulus(i == 12, '0, '0, '0, '0);
      tick();
      if (i == 17) checkOutput("extRestart", 32'(core_rst_o), 32'h3);
      if (i == 28) checkOutput("extHoldEnd", 32'(core_rst_o), 32'h3);
      if (i == 29) checkOutput("extRelease", 32'(core_rst_o), 32'h0);
    end

    // Interrupt vectors: level/edge latching, clear, set-beats-clear, masking.
    for (int j = 0; j < 15; j++) begin
      applyStimulus(1'b0, '0, vecs[j].src, vecs[j].mask, vecs[j].clr);
      tick();
      checkOutput($sformatf("vecPend%0d", j), 32'(irq_pending_o), 32'(vecs[j].expPend));
      checkOutput($sformatf("vecF2h%0d", j), f2h_irq_o, {30'b0, vecs[j].expF2h});
    end

    // Random traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      applyStimulus($urandom_range(0, 39) == 0,
                    {$urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0},
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
